alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_if.sv | 27 ++
 rtl/alu.sv | 133 +++++++++++++
 tb/tb_alu.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ALU operand/result bundle: the requester drives the opcode and operands,
// the ALU returns the registered result and its valid flag.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       i_alu_op;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic [WIDTH-1:0] o_alu_data;
    logic             o_insn_vld;

    modport master (
        output i_alu_op,
        output i_operand_a,
        output i_operand_b,
        input  o_alu_data,
        input  o_insn_vld
    );

    modport slave (
        input  i_alu_op,
        input  i_operand_a,
        input  i_operand_b,
        output o_alu_data,
        output o_insn_vld
    );
endinterface

// File: rtl/alu.sv
// Single-cycle registered integer ALU.
// One ripple-carry adder built from full-adder cells serves ADD, SUB, SLT and SLTU.
// One logarithmic right-shifter serves all shifts:
// - SLL reverses the bits on the way in and again on the way out.
// - SRA selects the sign bit as the fill bit.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op;

    assign op_a = bus.i_operand_a;
    assign op_b = bus.i_operand_b;
    assign op   = bus.i_alu_op;

    // ---------------- shared adder: a + (b ^ sub) + sub ----------------
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             overflow;
    logic             lt_signed;
    logic             lt_unsigned;

    assign sub_mode = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    assign b_eff    = op_b ^ {WIDTH{sub_mode}};
    assign carry[0] = sub_mode;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]      = op_a[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1]  = (op_a[gi] & b_eff[gi]) | (carry[gi] & (op_a[gi] ^ b_eff[gi]));
        end
    endgenerate

    // With a + ~b + 1, carry-out set means a >= b unsigned; signed compare
    // takes the sign of the difference corrected by overflow.
    assign overflow    = carry[WIDTH] ^ carry[WIDTH-1];
    assign lt_signed   = sum[WIDTH-1] ^ overflow;
    assign lt_unsigned = ~carry[WIDTH];

    // ---------------- barrel shifter ----------------
    logic [SHW-1:0]   shamt;
    logic             is_sll;
    logic             fill_bit;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_out;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] stage [SHW+1];

    assign shamt    = op_b[SHW-1:0];
    assign is_sll   = (op == OP_SLL);
    assign fill_bit = (op == OP_SRA) & op_a[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign a_rev[gi]   = op_a[WIDTH-1-gi];
            assign sll_res[gi] = sh_out[WIDTH-1-gi];
        end
    endgenerate

    assign sh_in    = is_sll ? a_rev : op_a;
    assign stage[0] = sh_in;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
            localparam int STEP = 1 << gi;
            assign stage[gi+1] = shamt[gi] ? {{STEP{fill_bit}}, stage[gi][WIDTH-1:STEP]}
                                           : stage[gi];
        end
    endgenerate

    assign sh_out = stage[SHW];

    // ---------------- result select ----------------
    logic [WIDTH-1:0] alu_data_next;
    logic             insn_vld_next;
    logic [WIDTH-1:0] alu_data_reg;
    logic             insn_vld_reg;

    // Pick the result for the current opcode; unsupported codes yield 0 / invalid.
    always_comb begin
        alu_data_next = '0;
        insn_vld_next = 1'b1;
        case (op)
            OP_ADD, OP_SUB: alu_data_next = sum;
            OP_SLT:         alu_data_next = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU:        alu_data_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_XOR:         alu_data_next = op_a ^ op_b;
            OP_OR:          alu_data_next = op_a | op_b;
            OP_AND:         alu_data_next = op_a & op_b;
            OP_SLL:         alu_data_next = sll_res;
            OP_SRL, OP_SRA: alu_data_next = sh_out;
            default: begin
                alu_data_next = '0;
                insn_vld_next = 1'b0;
            end
        endcase
    end

    // Capture a new result every edge; reset clears outputs immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_data_reg <= '0;
            insn_vld_reg <= 1'b0;
        end else begin
            alu_data_reg <= alu_data_next;
            insn_vld_reg <= insn_vld_next;
        end
    end

    assign bus.o_alu_data = alu_data_reg;
    assign bus.o_insn_vld = insn_vld_reg;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU; expected values are hand-computed.
module tb_alu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive on a falling edge, let the rising edge capture, check on the next falling edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input logic exp_vld);
        @(negedge clk);
        bus.i_alu_op    = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        @(negedge clk);
        check_eq({tag, ".data"}, bus.o_alu_data, exp_data);
        check_eq({tag, ".vld"}, {31'd0, bus.o_insn_vld}, {31'd0, exp_vld});
        $display("op=%b a=%08h b=%08h -> data=%08h vld=%0b (%s)", op, a, b,
                 bus.o_alu_data, bus.o_insn_vld, tag);
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        rst_n           = 1'b0;
        bus.i_alu_op    = 4'b0000;
        bus.i_operand_a = 32'd7;
        bus.i_operand_b = 32'd9;
        repeat (2) @(negedge clk);
        check_eq("reset.data", bus.o_alu_data, 32'h0);
        check_eq("reset.vld", {31'd0, bus.o_insn_vld}, 32'd0);
        rst_n = 1'b1;

        run_op("add_wrap",  4'b0000, 32'hFFFFFFFC, 32'h00000005, 32'h00000001, 1'b1);
        run_op("add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
        run_op("sub_neg",   4'b1000, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1);
        run_op("sub_ovf",   4'b1000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
        run_op("slt_neg",   4'b0010, 32'hFFFFFFFC, 32'h00000001, 32'h00000001, 1'b1);
        run_op("sltu_big",  4'b0011, 32'hFFFFFFFC, 32'h00000001, 32'h00000000, 1'b1);
        run_op("slt_ovf",   4'b0010, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
        run_op("slt_ovf2",  4'b0010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        run_op("sltu_lt",   4'b0011, 32'h00000001, 32'h00000002, 32'h00000001, 1'b1);
        run_op("sltu_eq",   4'b0011, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1);
        run_op("sra_1",     4'b1101, 32'hFFFFFFFC, 32'h00000001, 32'hFFFFFFFE, 1'b1);
        run_op("srl_1",     4'b0101, 32'hFFFFFFFC, 32'h00000001, 32'h7FFFFFFE, 1'b1);
        run_op("sll_33",    4'b0001, 32'hFFFFFFFC, 32'h00000021, 32'hFFFFFFF8, 1'b1);
        run_op("sll_0",     4'b0001, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFC, 1'b1);
        run_op("sra_0",     4'b1101, 32'h80000001, 32'h00000000, 32'h80000001, 1'b1);
        run_op("srl_31",    4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b1);
        run_op("sra_31",    4'b1101, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b1);
        run_op("sra_pos",   4'b1101, 32'h40000000, 32'h00000004, 32'h04000000, 1'b1);
        run_op("sll_31",    4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b1);
        run_op("sll_5",     4'b0001, 32'h0000000F, 32'hFFFFFF05, 32'h000001E0, 1'b1);
        run_op("xor",       4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1);
        run_op("or",        4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b1);
        run_op("and",       4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1);
        run_op("bad_1111",  4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        run_op("bad_1001",  4'b1001, 32'h12345678, 32'h87654321, 32'h00000000, 1'b0);
        run_op("after_bad", 4'b0000, 32'h00000002, 32'h00000003, 32'h00000005, 1'b1);

        // Reset asserted between edges clears the captured ADD immediately.
        run_op("pre_rst",   4'b0000, 32'h0000000A, 32'h00000014, 32'h0000001E, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async.data", bus.o_alu_data, 32'h0);
        check_eq("rst_async.vld", {31'd0, bus.o_insn_vld}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_hold.data", bus.o_alu_data, 32'h0);
        check_eq("rst_hold.vld", {31'd0, bus.o_insn_vld}, 32'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.i_alu_op    = 4'b0000;
        bus.i_operand_a = 32'h00000001;
        bus.i_operand_b = 32'h00000002;
        @(negedge clk);
        check_eq("post_rst.data", bus.o_alu_data, 32'h00000003);
        check_eq("post_rst.vld", {31'd0, bus.o_insn_vld}, 32'd1);
        $display("post-reset add -> data=%08h vld=%0b", bus.o_alu_data, bus.o_insn_vld);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
